// File: rtl/mem_stage_lsu.sv
// Memory-access stage controller: runs one data-cache transaction per memory
// instruction, stalls EX/MEM until it completes, and formats load results.
module mem_stage_lsu (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_unsigned,
  input  logic [3:0]  ls_size,
  input  logic [63:0] ls_address,
  input  logic [63:0] src2,
  input  logic        redirect_flush,
  output logic        dc_req_valid,
  input  logic        dc_req_ready,
  output logic [63:0] dc_req_addr,
  output logic        dc_req_wen,
  output logic [63:0] dc_req_wdata,
  output logic [7:0]  dc_req_wmask,
  input  logic        dc_resp_valid,
  input  logic [63:0] dc_resp_rdata,
  output logic        mem_stall,
  output logic        misaligned,
  output logic [63:0] opload_read_data_wb
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        memop;
  logic        mis_raw;
  logic        mis_access;
  logic        go;
  logic [2:0]  offset;
  logic [5:0]  bit_shift;
  logic        req_raw;
  logic        capture;
  logic        store_sel;
  logic [7:0]  base_mask;
  logic [63:0] shifted;
  logic [63:0] load_fmt;

  assign memop     = valid & (is_load | is_store);
  assign offset    = ls_address[2:0];
  assign bit_shift = {offset, 3'b000};

  always_comb begin
    mis_raw = 1'b0;
    case (ls_size)
      4'b0010: mis_raw = offset[0];
      4'b0100: mis_raw = |offset[1:0];
      4'b1000: mis_raw = |offset;
      default: mis_raw = 1'b0;
    endcase
  end

  assign mis_access = memop & mis_raw;
  assign go         = memop & ~mis_raw;
  assign misaligned = mis_access & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // REQ drops the request on a flush so nothing is accepted for a killed op.
  always_comb begin
    state_next = state;
    req_raw    = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        req_raw = go & ~redirect_flush;
        if (req_raw) begin
          state_next = dc_req_ready ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        req_raw = ~redirect_flush;
        if (redirect_flush) begin
          state_next = S_IDLE;
        end else if (dc_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dc_resp_valid) begin
          state_next = redirect_flush ? S_IDLE : S_DONE;
          capture    = ~redirect_flush & is_load;
        end else if (redirect_flush) begin
          state_next = S_DRAIN;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      S_DRAIN: begin
        if (dc_resp_valid) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign dc_req_valid = req_raw & ~reset;
  assign mem_stall    = ~reset & ((go & (state == S_IDLE || state == S_REQ || state == S_WAIT))
                                  | (state == S_DRAIN));

  assign dc_req_addr = {ls_address[63:3], 3'b000};
  assign store_sel   = valid & is_store;
  assign dc_req_wen  = store_sel;

  always_comb begin
    base_mask = '0;
    case (ls_size)
      4'b0001: base_mask = 8'h01;
      4'b0010: base_mask = 8'h03;
      4'b0100: base_mask = 8'h0F;
      4'b1000: base_mask = 8'hFF;
      default: base_mask = '0;
    endcase
  end

  assign dc_req_wdata = store_sel ? (src2 << bit_shift) : '0;
  assign dc_req_wmask = store_sel ? (base_mask << offset) : '0;

  always_comb begin
    shifted  = dc_resp_rdata >> bit_shift;
    load_fmt = shifted;
    case (ls_size)
      4'b0001: load_fmt = is_unsigned ? {56'd0, shifted[7:0]}
                                      : {{56{shifted[7]}}, shifted[7:0]};
      4'b0010: load_fmt = is_unsigned ? {48'd0, shifted[15:0]}
                                      : {{48{shifted[15]}}, shifted[15:0]};
      4'b0100: load_fmt = is_unsigned ? {32'd0, shifted[31:0]}
                                      : {{32{shifted[31]}}, shifted[31:0]};
      default: load_fmt = shifted;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      opload_read_data_wb <= '0;
    end else if (capture) begin
      opload_read_data_wb <= load_fmt;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, random transactions against
// an arithmetic reference model, and hand-written flush/reset sequences.
module tb_mem_stage_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid, is_load, is_store, is_unsigned;
  logic [3:0]  ls_size;
  logic [63:0] ls_address, src2;
  logic        redirect_flush;
  logic        dc_req_valid, dc_req_ready;
  logic [63:0] dc_req_addr;
  logic        dc_req_wen;
  logic [63:0] dc_req_wdata;
  logic [7:0]  dc_req_wmask;
  logic        dc_resp_valid;
  logic [63:0] dc_resp_rdata;
  logic        mem_stall, misaligned;
  logic [63:0] opload_read_data_wb;

  mem_stage_lsu dut (
    .clock(clock), .reset(reset), .valid(valid), .is_load(is_load),
    .is_store(is_store), .is_unsigned(is_unsigned), .ls_size(ls_size),
    .ls_address(ls_address), .src2(src2), .redirect_flush(redirect_flush),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_addr(dc_req_addr), .dc_req_wen(dc_req_wen),
    .dc_req_wdata(dc_req_wdata), .dc_req_wmask(dc_req_wmask),
    .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
    .mem_stall(mem_stall), .misaligned(misaligned),
    .opload_read_data_wb(opload_read_data_wb)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        vld, ld, st, uns;
    logic [3:0]  sz;
    logic [63:0] addr, src2, rdata;
    int          d1, d2;
    logic        e_mis;
    logic [63:0] e_addr, e_wdata;
    logic [7:0]  e_wmask;
    logic [63:0] e_res;
    int          e_stall;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] last_res = 64'h0;
  vec_t        tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    valid = 0; is_load = 0; is_store = 0; is_unsigned = 0; ls_size = 4'b0001;
    ls_address = 0; src2 = 0; redirect_flush = 0; dc_req_ready = 0;
    dc_resp_valid = 0; dc_resp_rdata = 0;
  endtask

  function automatic vec_t mkv(input logic vld, ld, st, uns, input logic [3:0] sz,
                               input logic [63:0] addr, s2, rd, input int d1, d2,
                               input logic mis, input logic [63:0] ea, ewd,
                               input logic [7:0] ewm, input logic [63:0] eres, input int est);
    vec_t v;
    v.vld = vld; v.ld = ld; v.st = st; v.uns = uns; v.sz = sz;
    v.addr = addr; v.src2 = s2; v.rdata = rd; v.d1 = d1; v.d2 = d2;
    v.e_mis = mis; v.e_addr = ea; v.e_wdata = ewd; v.e_wmask = ewm;
    v.e_res = eres; v.e_stall = est;
    return v;
  endfunction

  // Reference: byte counts, modular alignment and plain shift/mask arithmetic.
  function automatic vec_t model(input logic vld, ld, st, uns, input logic [3:0] sz,
                                 input logic [63:0] addr, s2, rd, input int d1, d2);
    vec_t v;
    int nb, off;
    logic [63:0] sh, lowm;
    logic [15:0] m;
    v.vld = vld; v.ld = ld; v.st = st; v.uns = uns; v.sz = sz;
    v.addr = addr; v.src2 = s2; v.rdata = rd; v.d1 = d1; v.d2 = d2;
    nb  = (sz == 4'b0001) ? 1 : (sz == 4'b0010) ? 2 : (sz == 4'b0100) ? 4 : 8;
    off = int'(addr[2:0]);
    v.e_mis   = vld && (ld || st) && ((off % nb) != 0);
    v.e_addr  = addr & ~64'h7;
    m         = ((16'd1 << nb) - 16'd1) << off;
    v.e_wmask = st ? m[7:0] : 8'h00;
    v.e_wdata = st ? (s2 << (8 * off)) : 64'h0;
    sh = rd >> (8 * off);
    if (nb == 8) begin
      v.e_res = sh;
    end else begin
      lowm    = (64'd1 << (8 * nb)) - 64'd1;
      v.e_res = sh & lowm;
      if (!uns && sh[8 * nb - 1]) v.e_res = v.e_res | ~lowm;
    end
    v.e_stall = (vld && (ld || st) && !v.e_mis) ? (d1 + d2 + 1) : 0;
    return v;
  endfunction

  // Called at posedge+1; plays the cache side and returns at posedge+1 idle.
  task automatic run_txn(input vec_t v, input string tag);
    int   k, sc;
    bit   acc, live;
    logic [63:0] er;
    valid = v.vld; is_load = v.ld; is_store = v.st; is_unsigned = v.uns;
    ls_size = v.sz; ls_address = v.addr; src2 = v.src2; redirect_flush = 0;
    live = v.vld && (v.ld || v.st) && !v.e_mis;
    acc = 0; sc = 0;
    for (k = 0; k < 40; k++) begin
      dc_req_ready  = (k >= v.d1);
      dc_resp_valid = live && (k == v.d1 + v.d2);
      dc_resp_rdata = dc_resp_valid ? v.rdata : ~v.rdata;
      @(negedge clock);
      if (k == 0) begin
        chk({tag, " misaligned"}, 64'(misaligned), 64'(v.e_mis));
        chk({tag, " req_valid0"}, 64'(dc_req_valid), 64'(live));
      end
      if (dc_req_valid) begin
        chk({tag, " req_addr"}, dc_req_addr, v.e_addr);
        chk({tag, " req_wen"}, 64'(dc_req_wen), 64'(v.st));
        chk({tag, " req_wdata"}, dc_req_wdata, v.e_wdata);
        chk({tag, " req_wmask"}, 64'(dc_req_wmask), 64'(v.e_wmask));
        if (dc_req_ready) acc = 1;
      end
      if (mem_stall) sc++;
      else break;
      nxt();
    end
    chk({tag, " stall_cycles"}, 64'(sc), 64'(v.e_stall));
    chk({tag, " accepted"}, 64'(acc), 64'(live));
    chk({tag, " req_valid_end"}, 64'(dc_req_valid), 64'h0);
    er = (live && v.ld) ? v.e_res : last_res;
    chk({tag, " result"}, opload_read_data_wb, er);
    last_res = er;
    nxt();
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    // Directed table: vld ld st uns size addr src2 rdata d1 d2 | mis addr wdata wmask result stall
    tbl[0]  = mkv(1,1,0,0,4'b0100,64'h1004,0,64'h8000_0001_DEAD_BEEF,0,1, 0,64'h1000,0,8'h00,64'hFFFF_FFFF_8000_0001,2);
    tbl[1]  = mkv(1,1,0,1,4'b0100,64'h1004,0,64'h8000_0001_DEAD_BEEF,0,1, 0,64'h1000,0,8'h00,64'h0000_0000_8000_0001,2);
    tbl[2]  = mkv(1,0,1,0,4'b0001,64'h2003,64'hAB,0,0,1, 0,64'h2000,64'h0000_0000_AB00_0000,8'h08,0,2);
    tbl[3]  = mkv(1,1,0,0,4'b1000,64'h4000,0,64'h0123_4567_89AB_CDEF,3,2, 0,64'h4000,0,8'h00,64'h0123_4567_89AB_CDEF,6);
    tbl[4]  = mkv(1,1,0,0,4'b0010,64'h3001,0,0,0,1, 1,64'h3000,0,8'h00,0,0);
    tbl[5]  = mkv(1,1,0,0,4'b0001,64'h5007,0,64'h80FF_0000_0000_0000,0,1, 0,64'h5000,0,8'h00,64'hFFFF_FFFF_FFFF_FF80,2);
    tbl[6]  = mkv(1,1,0,1,4'b0010,64'h6006,0,64'hBEEF_0000_0000_0000,1,2, 0,64'h6000,0,8'h00,64'h0000_0000_0000_BEEF,4);
    tbl[7]  = mkv(1,0,1,0,4'b1000,64'h7000,64'h1122_3344_5566_7788,0,2,3, 0,64'h7000,64'h1122_3344_5566_7788,8'hFF,0,6);
    tbl[8]  = mkv(1,0,1,0,4'b0010,64'h8006,64'hFFFF_FFFF_FFFF_1234,0,0,1, 0,64'h8000,64'h1234_0000_0000_0000,8'hC0,0,2);
    tbl[9]  = mkv(1,1,0,0,4'b0010,64'h3002,0,64'h0000_0000_8001_0000,0,3, 0,64'h3000,0,8'h00,64'hFFFF_FFFF_FFFF_8001,4);
    tbl[10] = mkv(1,1,0,1,4'b1000,64'h9008,0,64'hF000_0000_0000_0001,0,1, 0,64'h9008,0,8'h00,64'hF000_0000_0000_0001,2);
    tbl[11] = mkv(1,1,0,0,4'b1000,64'h9004,0,0,0,1, 1,64'h9000,0,8'h00,0,0);
    tbl[12] = mkv(1,0,1,0,4'b0100,64'hA002,64'h55,0,0,1, 1,64'hA000,0,8'h00,0,0);
    tbl[13] = mkv(0,1,0,0,4'b0010,64'h3001,0,0,0,1, 0,64'h3000,0,8'h00,0,0);

    // Reset with a live misaligned memop on the inputs: all flags forced low.
    reset = 1;
    valid = 1; is_load = 1; ls_size = 4'b0100; ls_address = 64'h1006;
    nxt();
    nxt();
    @(negedge clock);
    chk("reset req_valid", 64'(dc_req_valid), 64'h0);
    chk("reset stall", 64'(mem_stall), 64'h0);
    chk("reset misaligned", 64'(misaligned), 64'h0);
    chk("reset result", opload_read_data_wb, 64'h0);
    nxt();
    reset = 0;
    clear_inputs();

    for (int i = 0; i < 14; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Flush in WAIT: drain until the response, which is then discarded.
    valid = 1; is_load = 1; ls_size = 4'b1000; ls_address = 64'h100; dc_req_ready = 1;
    @(negedge clock);
    chk("drain accept", 64'(dc_req_valid), 64'h1);
    nxt();
    dc_req_ready = 0; redirect_flush = 1;
    @(negedge clock);
    chk("drain wait_stall", 64'(mem_stall), 64'h1);
    nxt();
    redirect_flush = 0; valid = 0;
    @(negedge clock);
    chk("drain stall", 64'(mem_stall), 64'h1);
    chk("drain no_req", 64'(dc_req_valid), 64'h0);
    nxt();
    dc_resp_valid = 1; dc_resp_rdata = 64'hDEAD_DEAD_DEAD_DEAD; redirect_flush = 1;
    @(negedge clock);
    chk("drain resp_stall", 64'(mem_stall), 64'h1);
    nxt();
    clear_inputs(); is_load = 1; ls_size = 4'b1000;
    @(negedge clock);
    chk("drain idle_stall", 64'(mem_stall), 64'h0);
    chk("drain result", opload_read_data_wb, last_res);
    nxt();
    clear_inputs();
    run_txn(tbl[0], "post_drain");

    // Flush together with the response in WAIT: straight back to IDLE.
    valid = 1; is_load = 1; ls_size = 4'b0100; ls_address = 64'h1004; dc_req_ready = 1;
    @(negedge clock);
    nxt();
    dc_req_ready = 0; dc_resp_valid = 1; dc_resp_rdata = 64'h1234_5678_0000_0000; redirect_flush = 1;
    @(negedge clock);
    chk("flushresp stall", 64'(mem_stall), 64'h1);
    nxt();
    clear_inputs();
    @(negedge clock);
    chk("flushresp idle_stall", 64'(mem_stall), 64'h0);
    chk("flushresp result", opload_read_data_wb, last_res);
    nxt();

    // Flush while held in REQ withdraws the request.
    valid = 1; is_load = 1; ls_size = 4'b1000; ls_address = 64'h200;
    @(negedge clock);
    chk("reqflush req0", 64'(dc_req_valid), 64'h1);
    chk("reqflush stall0", 64'(mem_stall), 64'h1);
    nxt();
    @(negedge clock);
    chk("reqflush req1", 64'(dc_req_valid), 64'h1);
    nxt();
    redirect_flush = 1;
    @(negedge clock);
    chk("reqflush stall2", 64'(mem_stall), 64'h1);
    nxt();
    clear_inputs();
    @(negedge clock);
    chk("reqflush idle_stall", 64'(mem_stall), 64'h0);
    chk("reqflush idle_req", 64'(dc_req_valid), 64'h0);
    nxt();
    run_txn(tbl[2], "post_reqflush");

    // Flush in IDLE: no request, stall follows the live memop.
    valid = 1; is_load = 1; ls_size = 4'b0100; ls_address = 64'h1004;
    dc_req_ready = 1; redirect_flush = 1;
    @(negedge clock);
    chk("idleflush req", 64'(dc_req_valid), 64'h0);
    chk("idleflush stall", 64'(mem_stall), 64'h1);
    nxt();
    clear_inputs();
    run_txn(tbl[5], "post_idleflush");

    // Reset while in WAIT, then a stray response must be ignored.
    valid = 1; is_load = 1; ls_size = 4'b0100; ls_address = 64'h1004; dc_req_ready = 1;
    @(negedge clock);
    nxt();
    reset = 1; ls_address = 64'h1006;
    @(negedge clock);
    chk("rstwait req", 64'(dc_req_valid), 64'h0);
    chk("rstwait stall", 64'(mem_stall), 64'h0);
    chk("rstwait mis", 64'(misaligned), 64'h0);
    nxt();
    reset = 0; valid = 0; ls_address = 64'h1004; dc_req_ready = 0;
    dc_resp_valid = 1; dc_resp_rdata = 64'h7777_7777_7777_7777;
    @(negedge clock);
    chk("stray stall", 64'(mem_stall), 64'h0);
    chk("stray req", 64'(dc_req_valid), 64'h0);
    chk("rst result", opload_read_data_wb, 64'h0);
    nxt();
    dc_resp_valid = 0;
    @(negedge clock);
    chk("stray result", opload_read_data_wb, 64'h0);
    last_res = 64'h0;
    nxt();
    clear_inputs();
    run_txn(tbl[9], "post_reset");

    // Random transactions against the reference model.
    for (int i = 0; i < 200; i++) begin
      logic vld, ld, st, uns;
      logic [3:0] sz;
      logic [63:0] addr;
      int op;
      vld  = ($urandom_range(0, 9) != 0);
      op   = $urandom_range(0, 9);
      ld   = (op < 5);
      st   = (op >= 5 && op < 9);
      uns  = $urandom_range(0, 1);
      sz   = 4'b0001 << $urandom_range(0, 3);
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) addr[2:0] = addr[2:0] & ~(3'(sz) - 3'd1);
      run_txn(model(vld, ld, st, uns, sz, addr, {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(1, 3)), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
